// File: rtl/spi_target_pkg.sv
// Shared constants, state encoding and command decode for the BIFROST SPI target port.
package spi_target_pkg;

    localparam logic [7:0] CMD_WRITE       = 8'h02;
    localparam logic [7:0] CMD_READ        = 8'h03;
    localparam int         SPI_TGT_DIV_MIN = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WRITE,
        OP_READ
    } op_t;

    function automatic op_t decode_cmd(input logic [7:0] cmd);
        case (cmd)
            CMD_WRITE: return OP_WRITE;
            CMD_READ:  return OP_READ;
            default:   return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// N-stage synchronizer for an asynchronous pin, with registered-history rise/fall detect.
module spi_target_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic              level;

    // Clearing to 0 means a pin already low at reset release shows no falling edge,
    // so a frame interrupted by reset is only re-entered through a fresh cs_n fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage captures its neighbour's old value,
            // giving a true shift chain instead of a single flop.
            chain <= {chain[STAGES-2:0], raw};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target bridging an external host onto the BIFROST register bus.
// Pins are oversampled on clock; register accesses leave as one-cycle strobes.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clock (clock),
        .reset (reset),
        .raw   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clock (clock),
        .reset (reset),
        .raw   (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) mosi_chain <= '0;
        else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_bit_q, miso_bit_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       load_q, load_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    op_t        cmd_op;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_bit_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_bit_q <= miso_bit_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            load_q     <= load_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value is given its hold value first, so no branch
        // that skips an assignment can infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_bit_d = miso_bit_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        load_d     = re_q;
        rx_byte    = {rx_q[6:0], mosi_s};
        cmd_op     = decode_cmd(rx_byte);
        byte_done  = sck_rise && (bit_cnt_q == 3'd7);

        // cs_n release wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d    = ST_CMD;
                op_d       = OP_NONE;
                bit_cnt_d  = '0;
                rx_d       = '0;
                miso_bit_d = 1'b0;
            end
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sck_fall && (state_q == ST_RDATA)) begin
                miso_bit_d = tx_q[7];
                tx_d       = {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        op_d    = cmd_op;
                        state_d = (cmd_op == OP_NONE) ? ST_IGNORE : ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_d = rx_byte;
                        if (op_q == OP_READ) begin
                            re_d    = 1'b1;
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        wdata_d = rx_byte;
                        we_d    = 1'b1;
                    end
                    ST_RDATA: re_d = 1'b1;
                    default: ;
                endcase
            end
        end

        // Strobe follow-up: read data lands the cycle after reg_re, and the address
        // advances once the current access has been presented.
        if (load_q) begin
            tx_d   = reg_rdata;
            addr_d = addr_q + 8'd1;
        end
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign miso      = (state_q == ST_RDATA) ? miso_bit_q : 1'b0;
    assign busy      = (state_q != ST_IDLE) && !cs_rise;
    assign miso_oe   = busy;

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) port on the BIFRÖST CPLD that lets an external SPI host (debug programmer or a second board) read and write the 256-byte BIFRÖST register space. It is the responder counterpart of the on-board SPI initiator: the host drives SCK, CS and MOSI on the expansion pins, and this block drives MISO. All SPI inputs are oversampled on the system clock, and register accesses are issued as single-cycle strobes into the BIFRÖST register decode.

## Interface

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sck/cs_n/mosi (minimum 2)

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- sck  in  1  host SPI clock, asynchronous
- cs_n  in  1  host chip select, active-low, asynchronous
- mosi  in  1  host data out
- miso  out  1  target data out
- miso_oe  out  1  high while the frame is selected; the top level tri-states miso when low
- reg_addr  out  8  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_re
- busy  out  1  high while cs_n (synchronized) is low

## Operation

- Protocol: SPI mode 0, MSB first. The target samples mosi on SCK rising edges and shifts miso on SCK falling edges.
- Frame layout: byte 0 is the command, byte 1 is the address, and bytes 2..n are data.
- Commands: 0x02 is WRITE and 0x03 is READ. Any other command is ignored for the rest of the frame.
- States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
- IDLE → CMD on synchronized cs_n falling edge. The bit counter and shift register clear.
- CMD → ADDR after 8 bits.
  - Command 0x02 latches a write flag.
  - Command 0x03 latches a read flag.
  - Any other value goes to IGNORE.
- ADDR → WDATA or RDATA after 8 bits. The address register loads the received byte.
  - For READ, reg_re pulses in the same cycle with reg_addr equal to the new address.
  - The next cycle, reg_rdata loads into the tx shift register, and the address increments.
- WDATA: after each 8th bit:
  - reg_we pulses for one cycle with reg_addr and reg_wdata equal to the received byte.
  - The next cycle, the address increments.
- RDATA: after each 8th bit, the block prefetches the next byte the same way as in ADDR (reg_re, then load, then increment). Bytes received on mosi are discarded.
- Address arithmetic is 8-bit and wraps from 0xFF to 0x00.
- miso:
  - Drives the tx shift MSB only in RDATA. It is 0 in every other state.
  - miso_oe is high from cs_n falling to cs_n rising, in every state including IGNORE.
- Synchronized cs_n rising in any state:
  - Next state is IDLE.
  - A partial byte is discarded: no reg_we, no reg_re.
  - miso_oe drops the same cycle.
- reset overrides everything, including mid-frame. The block must then wait for a fresh cs_n falling edge before decoding again.
- Reset values:
  - state IDLE, miso 0, miso_oe 0, busy 0.
  - reg_we 0, reg_re 0, reg_addr 0x00, reg_wdata 0x00.

## Timing

- Synchronizer delay is SYNC_STAGES cycles, plus 1 cycle for edge detection.
- Maximum SCK frequency is clock/16, so each SCK half-period is at least 8 system clocks.
- Read prefetch timeline, counted from the detected 8th rising edge:
  - cycle 0: reg_re.
  - cycle 1: tx shift load.
  - The detected falling edge then shifts the MSB out, which is at least 4 cycles of margin.
- The first read data bit is on miso before the first SCK rising edge of byte 2.
- reg_we occurs 1 cycle after the detected 8th rising edge of each write data byte.
- reg_we and reg_re are never high together, and never on consecutive cycles for the same address.
- SCK edges while cs_n is high are ignored.
- cs_n rising and an SCK edge in the same cycle: cs_n wins and the edge is ignored.

## Structure

- Shared package constants:
  - CMD_WRITE = 8'h02, CMD_READ = 8'h03.
  - The state encoding.
  - SPI_TGT_DIV_MIN = 16.
- Sub-module spi_target_sync: an N-stage synchronizer plus rise/fall edge detect, instantiated for sck and cs_n (mosi uses the synchronizer only).
- The FSM, counters and shift registers live in spi_target.

## Test plan

- **Single write:** reset, then frame 02 00 A5 at clock/16. Expect exactly one reg_we with reg_addr=0x00 and reg_wdata=0xA5, and no reg_re.
- **Burst read with wrap:** frame 03 FE xx xx xx with the model returning rdata=addr^0x5A. Expect miso bytes 0xA4, 0xA5, 0x5A and reg_re at addresses FE, FF, 00, 01.
- **Abort mid-byte:** frame 02 10 then 5 bits, then cs_n high. Expect no reg_we, the state back in IDLE, and miso_oe going 0 in the same cycle busy drops.
- **Unknown command:** frame 7F 00 11 22. Expect no strobes, miso held 0, and miso_oe high for the full frame.
- **Reset mid-frame:** during byte 2 of 02 20 33, assert reset for 1 cycle. Expect all outputs at their reset values, no reg_we, and SCK edges ignored until the next cs_n falling edge. A following frame 02 21 44 must produce reg_we at 0x21 with data 0x44.
